platform_scan_scheduler: RTL
============================

Name: platform_scan_scheduler

Overview:
- Time-shares the single platform-detector datapath among up to N_REQ actors (player, enemies) that need floor/platform information.
- Per frame, grants the detector to one requester, chosen round-robin.
- Drives the detector's actor X/Y/height inputs and arm control, then captures the detected platform (X1, X2, Y) or a not-found result.
- Returns the result tagged with the requester ID. Sits between the actor/physics logic and the detector, clocked by the frame/pixel clock.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width, equal to clog2(N_REQ).

Ports:
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- VS  in  1  vertical sync, active-low; a frame starts on its falling edge.
- req  in  N_REQ  per-requester scan request, level-sensitive.
- req_x  in  10*N_REQ  packed requester X; slice i is bits [10i+9:10i].
- req_y  in  10*N_REQ  packed requester Y.
- req_h  in  10*N_REQ  packed requester height.
- det_valid  in  1  detector reports platform found; level, held until the detector clears on VS low.
- det_x1, det_x2, det_y  in  10 each  detector platform result.
- det_px, det_py, det_ph  out  10 each  actor coordinates driven to the detector.
- det_arm  out  1  enables detector search; maps to the detector's scroll/override enable.
- grant  out  N_REQ  one-hot current owner; all zero when idle.
- busy  out  1  high in any state other than IDLE.
- res_valid  out  1  one-cycle result strobe.
- res_id  out  IDW  requester index of the result.
- res_found  out  1  1 = platform found, 0 = timed out.
- res_x1, res_x2, res_y  out  10 each  captured platform; zero when res_found = 0.

Behaviour:
- Reset (asynchronous, Reset = 0):
  - state = IDLE, RR pointer = 0.
  - VS_q = 1.
  - All outputs 0: grant, busy, det_arm, det_px/py/ph, res_*.
- vs_fall = VS_q & ~VS, where VS_q is VS registered each cycle.
- IDLE:
  - If req is nonzero, select the first set bit at or after the pointer, wrapping modulo N_REQ.
  - Set grant one-hot.
  - Latch that requester's x/y/h into det_px/py/ph; these stay stable until release.
  - Next state: WAIT_FRAME. Decision latency is 1 cycle from req assertion.
  - If req is zero, stay in IDLE.
- WAIT_FRAME:
  - det_arm = 0.
  - On vs_fall, go to SCAN.
  - The scan never starts mid-frame, so the detector always sees a full frame.
- SCAN:
  - det_arm = 1.
  - If det_valid = 1: latch det_x1/x2/y, set found = 1, go to REPORT.
  - Else on vs_fall (frame ended with nothing found): found = 0, results zero, go to REPORT.
  - If det_valid and vs_fall occur in the same cycle, det_valid wins and found = 1.
- REPORT (1 cycle):
  - res_valid = 1; res_id = the granted index; res_found and res_* hold the latched values.
  - det_arm = 0.
  - Pointer = granted index + 1, wrapping N_REQ-1 to 0.
  - grant cleared; go to IDLE.
  - res_* hold their values until the next REPORT. Only res_valid pulses.
- Request rules:
  - Deasserting req after grant does not abort. The scan completes and is reported.
  - Latched coordinates ignore later changes to req_x/y/h.
  - A requester still requesting after REPORT competes again, but sits at lowest priority in the rotation.
- Fairness: with all N_REQ requesting continuously, every requester receives exactly one result per N_REQ grants.
- Reset mid-operation: immediate return to IDLE with all outputs cleared. No res_valid is issued for the aborted scan.
- Arithmetic: no arithmetic beyond the pointer increment modulo N_REQ. All coordinate paths are 10-bit pass-through.

Test Plan:
- Reset held low with req = 4'b1111 → grant = 0, busy = 0, res_valid never asserts. Release reset → grant = 4'b0001 after 1 cycle.
- req = 4'b0100 with req_x/y/h[2] = 120/200/32 → grant = 4'b0100, det_px/py/ph = 120/200/32. det_arm rises 1 cycle after the next VS fall. Drive det_valid with x1/x2/y = 100/180/240 → res_valid pulse with id = 2, found = 1, 100/180/240.
- Granted requester, det_valid never asserted → at the following VS fall, res_valid with found = 0, res_x1/x2/y = 0.
- req = 4'b1111 held for 8 scans → res_id sequence 0, 1, 2, 3, 0, 1, 2, 3.
- det_valid and vs_fall in the same SCAN cycle → res_found = 1 with the det_* values. Separately, dropping req mid-SCAN → the result is still reported.
- Reset asserted during SCAN → state IDLE and det_arm = 0 immediately, no res_valid. The pointer restarts at 0.

Source files
------------

// File: rtl/platform_scan_scheduler.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | platform_scan_scheduler: round-robin time-sharing of the platform        |
// | detector among N_REQ actors, one scan per granted frame.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module platform_scan_scheduler #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  vs_i,
    input  logic [N_REQ-1:0]      req_i,
    input  logic [10*N_REQ-1:0]   req_x_i,
    input  logic [10*N_REQ-1:0]   req_y_i,
    input  logic [10*N_REQ-1:0]   req_h_i,
    input  logic                  det_valid_i,
    input  logic [9:0]            det_x1_i,
    input  logic [9:0]            det_x2_i,
    input  logic [9:0]            det_y_i,
    output logic [9:0]            det_px_o,
    output logic [9:0]            det_py_o,
    output logic [9:0]            det_ph_o,
    output logic                  det_arm_o,
    output logic [N_REQ-1:0]      grant_o,
    output logic                  busy_o,
    output logic                  res_valid_o,
    output logic [IDW-1:0]        res_id_o,
    output logic                  res_found_o,
    output logic [9:0]            res_x1_o,
    output logic [9:0]            res_x2_o,
    output logic [9:0]            res_y_o
);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_WAIT_FRAME = 2'd1,
        S_SCAN       = 2'd2,
        S_REPORT     = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     gid_q, gid_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               vs_q;
    logic [9:0]         px_q, px_d, py_q, py_d, ph_q, ph_d;
    logic [IDW-1:0]     rid_q, rid_d;
    logic               found_q, found_d;
    logic [9:0]         rx1_q, rx1_d, rx2_q, rx2_d, ry_q, ry_d;

    logic               vs_fall_w;
    logic               sel_valid_w;
    logic [IDW-1:0]     sel_idx_w;
    logic [IDW:0]       sum_w;
    logic [9:0]         sel_x_w, sel_y_w, sel_h_w;

    assign vs_fall_w = vs_q & ~vs_i;

    // Descending scan so the nearest set bit at/after the pointer wins.
    always_comb begin
        sel_valid_w = 1'b0;
        sel_idx_w   = '0;
        sum_w       = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            sum_w = {1'b0, ptr_q} + (IDW+1)'(k);
            if (sum_w >= (IDW+1)'(N_REQ))
                sum_w = sum_w - (IDW+1)'(N_REQ);
            if (req_i[sum_w[IDW-1:0]]) begin
                sel_valid_w = 1'b1;
                sel_idx_w   = sum_w[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_x_w = '0;
        sel_y_w = '0;
        sel_h_w = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (sel_idx_w == IDW'(i)) begin
                sel_x_w = req_x_i[10*i +: 10];
                sel_y_w = req_y_i[10*i +: 10];
                sel_h_w = req_h_i[10*i +: 10];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gid_d   = gid_q;
        grant_d = grant_q;
        px_d    = px_q;
        py_d    = py_q;
        ph_d    = ph_q;
        rid_d   = rid_q;
        found_d = found_q;
        rx1_d   = rx1_q;
        rx2_d   = rx2_q;
        ry_d    = ry_q;
        case (state_q)
            S_IDLE: begin
                if (sel_valid_w) begin
                    gid_d   = sel_idx_w;
                    grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << sel_idx_w;
                    px_d    = sel_x_w;
                    py_d    = sel_y_w;
                    ph_d    = sel_h_w;
                    state_d = S_WAIT_FRAME;
                end
            end
            S_WAIT_FRAME: begin
                if (vs_fall_w)
                    state_d = S_SCAN;
            end
            S_SCAN: begin
                // A hit in the last cycle of the frame still counts as found.
                if (det_valid_i) begin
                    found_d = 1'b1;
                    rx1_d   = det_x1_i;
                    rx2_d   = det_x2_i;
                    ry_d    = det_y_i;
                    rid_d   = gid_q;
                    state_d = S_REPORT;
                end else if (vs_fall_w) begin
                    found_d = 1'b0;
                    rx1_d   = '0;
                    rx2_d   = '0;
                    ry_d    = '0;
                    rid_d   = gid_q;
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                grant_d = '0;
                ptr_d   = (gid_q == IDW'(N_REQ - 1)) ? '0 : gid_q + IDW'(1);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            gid_q   <= '0;
            grant_q <= '0;
            vs_q    <= 1'b1;
            px_q    <= '0;
            py_q    <= '0;
            ph_q    <= '0;
            rid_q   <= '0;
            found_q <= 1'b0;
            rx1_q   <= '0;
            rx2_q   <= '0;
            ry_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            grant_q <= grant_d;
            vs_q    <= vs_i;
            px_q    <= px_d;
            py_q    <= py_d;
            ph_q    <= ph_d;
            rid_q   <= rid_d;
            found_q <= found_d;
            rx1_q   <= rx1_d;
            rx2_q   <= rx2_d;
            ry_q    <= ry_d;
        end
    end

    assign det_px_o    = px_q;
    assign det_py_o    = py_q;
    assign det_ph_o    = ph_q;
    assign det_arm_o   = (state_q == S_SCAN);
    assign grant_o     = grant_q;
    assign busy_o      = (state_q != S_IDLE);
    assign res_valid_o = (state_q == S_REPORT);
    assign res_id_o    = rid_q;
    assign res_found_o = found_q;
    assign res_x1_o    = rx1_q;
    assign res_x2_o    = rx2_q;
    assign res_y_o     = ry_q;

endmodule
`default_nettype wire
